// File: rtl/fifo_sync.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, flush and sticky error flags.
// Show-ahead (data visible once stored) or registered read (1-cycle latency); writes while full are dropped.
module fifo_sync #(
  parameter int LOG2_DEPTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SHOWAHEAD     = 1,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic [LOG2_DEPTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int PW    = LOG2_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a read cannot make room for a same-cycle write.
  always_comb begin
    wr_acc = wr_i && !full_q && !flush_i;
    rd_acc = rd_i && !empty_q && !flush_i;
    head_d = head_q + PW'(wr_acc);
    tail_d = tail_q + PW'(rd_acc);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
    level_d  = head_d - tail_d;
    empty_d  = (level_d == '0);
    full_d   = (level_d == PW'(DEPTH));
    afull_d  = (level_d >= PW'(AFULL_THRESH));
    aempty_d = (level_d <= PW'(AEMPTY_THRESH));
    ovf_d    = !flush_i && (ovf_q || (wr_i && full_q));
    unf_d    = !flush_i && (unf_q || (rd_i && empty_q));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_acc) begin
      mem_q[head_q[LOG2_DEPTH-1:0]] <= data_i;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      assign data_o  = mem_q[tail_q[LOG2_DEPTH-1:0]];
      assign valid_o = !empty_q;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;
        if (rd_acc) begin
          rdata_d = mem_q[tail_q[LOG2_DEPTH-1:0]];
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign data_o  = rdata_q;
      assign valid_o = rvalid_q;
    end
  endgenerate

  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign afull_o     = afull_q;
  assign aempty_o    = aempty_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Drives one show-ahead and one registered-read fifo_sync with identical stimulus and
// compares both against a queue-based reference of the FIFO's rules.
module tb_fifo_sync;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       wr_i = 1'b0;
  logic       rd_i = 1'b0;
  logic [7:0] data_i = '0;

  logic [7:0] sa_data, rg_data;
  logic       sa_valid, rg_valid, sa_empty, rg_empty, sa_full, rg_full;
  logic       sa_afull, rg_afull, sa_aempty, rg_aempty;
  logic [4:0] sa_level, rg_level;
  logic       sa_ovf, rg_ovf, sa_unf, rg_unf;

  always #5 clk = ~clk;

  fifo_sync #(.LOG2_DEPTH(4), .DATA_WIDTH(8), .SHOWAHEAD(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_sa (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .data_i(data_i), .wr_i(wr_i), .rd_i(rd_i),
    .data_o(sa_data), .valid_o(sa_valid), .empty_o(sa_empty), .full_o(sa_full), .afull_o(sa_afull),
    .aempty_o(sa_aempty), .level_o(sa_level), .overflow_o(sa_ovf), .underflow_o(sa_unf)
  );

  fifo_sync #(.LOG2_DEPTH(4), .DATA_WIDTH(8), .SHOWAHEAD(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_rg (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .data_i(data_i), .wr_i(wr_i), .rd_i(rd_i),
    .data_o(rg_data), .valid_o(rg_valid), .empty_o(rg_empty), .full_o(rg_full), .afull_o(rg_afull),
    .aempty_o(rg_aempty), .level_o(rg_level), .overflow_o(rg_ovf), .underflow_o(rg_unf)
  );

  // Reference state: contents as a queue plus sticky flags.
  logic [7:0] mq[$];
  logic [7:0] exp_sa[$];
  logic [7:0] exp_rg[$];
  bit         m_ovf, m_unf, exp_rvld;
  logic [7:0] reg_last;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int lvl;
    lvl = mq.size();
    chk("sa_level", 32'(sa_level), lvl);
    chk("rg_level", 32'(rg_level), lvl);
    chk("sa_empty", 32'(sa_empty), 32'(lvl == 0));
    chk("rg_empty", 32'(rg_empty), 32'(lvl == 0));
    chk("sa_full", 32'(sa_full), 32'(lvl == DEPTH));
    chk("rg_full", 32'(rg_full), 32'(lvl == DEPTH));
    chk("sa_afull", 32'(sa_afull), 32'(lvl >= 12));
    chk("rg_afull", 32'(rg_afull), 32'(lvl >= 12));
    chk("sa_aempty", 32'(sa_aempty), 32'(lvl <= 2));
    chk("rg_aempty", 32'(rg_aempty), 32'(lvl <= 2));
    chk("sa_overflow", 32'(sa_ovf), 32'(m_ovf));
    chk("rg_overflow", 32'(rg_ovf), 32'(m_ovf));
    chk("sa_underflow", 32'(sa_unf), 32'(m_unf));
    chk("rg_underflow", 32'(rg_unf), 32'(m_unf));
    chk("sa_valid", 32'(sa_valid), 32'(lvl != 0));
    chk("rg_valid", 32'(rg_valid), 32'(exp_rvld));
    chk("rg_data_hold", 32'(rg_data), 32'(reg_last));
    if (lvl != 0) chk("sa_head_word", 32'(sa_data), 32'(mq[0]));
  endtask

  // One clock cycle: drive inputs, apply the FIFO rules to the reference, then check after the edge.
  task automatic step(input bit rst, input bit fl, input bit wr, input bit rd, input logic [7:0] din);
    bit wacc, racc;
    logic [7:0] e;
    reset_i = rst; flush_i = fl; wr_i = wr; rd_i = rd; data_i = din;
    exp_rvld = 1'b0;
    if (rst) begin
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; reg_last = 8'h00;
    end else if (fl) begin
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      wacc = wr && (mq.size() < DEPTH);
      racc = rd && (mq.size() > 0);
      if (wr && mq.size() == DEPTH) m_ovf = 1'b1;
      if (rd && mq.size() == 0) m_unf = 1'b1;
      if (racc) begin
        e = mq.pop_front();
        exp_sa.push_back(e);
        exp_rg.push_back(e);
        reg_last = e;
        exp_rvld = 1'b1;
      end
      if (wacc) mq.push_back(din);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitors: show-ahead word is consumed when rd hits a valid head; registered word appears on valid_o.
  always @(negedge clk) begin
    if (rd_i === 1'b1 && sa_valid === 1'b1 && reset_i === 1'b0 && flush_i === 1'b0) begin
      if (exp_sa.size() == 0) chk("sa_unexpected_pop", 32'(sa_data), 32'hFFFF_FFFF);
      else chk("sa_read_data", 32'(sa_data), 32'(exp_sa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rg_valid === 1'b1) begin
      if (exp_rg.size() == 0) chk("rg_unexpected_valid", 32'(rg_data), 32'hFFFF_FFFF);
      else chk("rg_read_data", 32'(rg_data), 32'(exp_rg.pop_front()));
    end
  end

  initial begin
    reg_last = 8'h00;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(i));
    step(0, 0, 1, 0, 8'hFF);

    // Drain, then one read of an empty FIFO.
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // Steady stream at level 5; pointers wrap repeatedly.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1, 8'($urandom));

    // Fill to 10 and flush with concurrent wr/rd, then one word round trip.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'($urandom));
    step(0, 1, 1, 1, 8'h77);
    step(0, 0, 1, 0, 8'h3C);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Registered read of 0xA5 and data hold afterwards.
    step(0, 0, 1, 0, 8'hA5);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Level 7 with overflow set, then reset.
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 8'h00);
    step(1, 0, 1, 1, 8'h55);
    step(0, 0, 0, 0, 8'h00);

    // Random traffic: write-heavy then read-heavy, with rare flush/reset.
    for (int i = 0; i < 1200; i++) begin
      bit wr, rd, fl, rst;
      int wbias;
      wbias = (i < 600) ? 65 : 35;
      wr  = ($urandom_range(0, 99) < wbias);
      rd  = ($urandom_range(0, 99) < (100 - wbias));
      fl  = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 127) == 0);
      step(rst, fl, wr, rd, 8'($urandom));
    end
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    chk("sa_scoreboard_drained", exp_sa.size(), 0);
    chk("rg_scoreboard_drained", exp_rg.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
